// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32 instruction fetch stage.
package rv32_fetch_pkg;

    localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
    localparam int unsigned FAULT_CAUSE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_HOLD  = 2'b10,
        S_FAULT = 2'b11
    } fetch_state_e;

    typedef enum logic [FAULT_CAUSE_W-1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fault_cause_e;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter for an outstanding instruction-memory request.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Saturates at LAST so it never wraps back to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = (r_cnt == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: samples the PC, reads instruction memory over req/ack and hands the
// word to decode under valid/ready, stalling the PC until it is consumed.
module instr_fetch
    import rv32_fetch_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      TIMEOUT  = 16,
    parameter logic [XLEN-1:0]  NOP_WORD = XLEN'(rv32_fetch_pkg::NOP_WORD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    input  logic            fetch_en,
    input  logic            redirect,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ack,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            pc_stall,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause
);

    fetch_state_e    r_state;
    fault_cause_e    r_cause;
    logic [XLEN-1:0] r_imem_addr;
    logic [XLEN-1:0] r_instr_out;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_imem_req;
    logic            r_valid;
    logic            r_fault;

    logic w_accept;
    logic w_sample;
    logic w_misalign;
    logic w_expired;
    logic w_ctr_clear;
    logic w_ctr_inc;

    // r_valid is only set in HOLD; a redirect hides it from decode.
    assign w_accept   = r_valid & ~redirect & instr_ready;
    assign w_sample   = fetch_en & ~redirect &
                        ((r_state == S_IDLE) | ((r_state == S_HOLD) & w_accept));
    assign w_misalign = is_misaligned(pc_in[1:0]);
    assign w_ctr_clear = w_sample & ~w_misalign;
    assign w_ctr_inc   = (r_state == S_REQ) & ~imem_ack & ~redirect;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_ctr_clear),
        .inc     (w_ctr_inc),
        .expired (w_expired)
    );

    // FSM and data registers; a PC sample overrides the HOLD release decision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cause     <= FC_NONE;
            r_imem_addr <= '0;
            r_instr_out <= NOP_WORD;
            r_instr_pc  <= '0;
            r_imem_req  <= 1'b0;
            r_valid     <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect) begin
                        r_state    <= S_IDLE;
                        r_imem_req <= 1'b0;
                    end else if (imem_ack) begin
                        r_instr_out <= imem_rdata;
                        r_instr_pc  <= r_imem_addr;
                        r_state     <= S_HOLD;
                        r_imem_req  <= 1'b0;
                        r_valid     <= 1'b1;
                    end else if (w_expired) begin
                        r_state    <= S_FAULT;
                        r_imem_req <= 1'b0;
                        r_fault    <= 1'b1;
                        r_cause    <= FC_TIMEOUT;
                    end
                end
                S_HOLD: begin
                    if (redirect || w_accept) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_sample) begin
                r_imem_addr <= pc_in;
                if (w_misalign) begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                    r_cause <= FC_MISALIGN;
                end else begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign instr_out   = r_instr_out;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid & ~redirect;
    assign pc_stall    = (r_state == S_FAULT) | ~(redirect | w_accept);
    assign fetch_fault = r_fault;
    assign fault_cause = r_cause;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized traffic
// compared every cycle against a request/word-level reference model.
module tb_instr_fetch;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic [XLEN-1:0] pc_in;
    logic            fetch_en;
    logic            redirect;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_ack;
    logic [XLEN-1:0] instr_out;
    logic [XLEN-1:0] instr_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic            pc_stall;
    logic            fetch_fault;
    logic [1:0]      fault_cause;

    instr_fetch #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT),
        .NOP_WORD(NOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .fetch_en   (fetch_en),
        .redirect   (redirect),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .instr_out  (instr_out),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc_stall   (pc_stall),
        .fetch_fault(fetch_fault),
        .fault_cause(fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Memory contents are a fixed scramble of the address unless overridden.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    int          mem_mode  = 0;   // 0 zero-wait, 1 random latency, 2 never ack
    bit          force_en  = 1'b0;
    logic [31:0] force_data = '0;

    // Advance one clock; the memory answers from the request visible after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        case (mem_mode)
            0:       imem_ack = imem_req;
            1:       imem_ack = imem_req && ($urandom_range(0, 2) == 0);
            default: imem_ack = 1'b0;
        endcase
        if (imem_ack) imem_rdata = force_en ? force_data : mem_fn(imem_addr);
        else          imem_rdata = $urandom;
    endtask

    // Reference model: one outstanding request, at most one held word, sticky fault.
    bit          m_busy, m_have;
    int          m_wait;
    int          m_cause;
    logic [31:0] m_addr, m_out, m_pc;

    always @(posedge clk) begin
        bit acc;
        bit start;
        if (!rst) begin
            m_busy = 0; m_have = 0; m_wait = 0; m_cause = 0;
            m_addr = '0; m_out = NOP; m_pc = '0;
        end else if (m_cause == 0) begin
            acc   = m_have && !redirect && instr_ready;
            start = fetch_en && !redirect && ((!m_busy && !m_have) || acc);
            if (m_have) begin
                if (redirect || acc) m_have = 0;
            end else if (m_busy) begin
                if (redirect) m_busy = 0;
                else if (imem_ack) begin
                    m_out = imem_rdata; m_pc = m_addr; m_have = 1; m_busy = 0;
                end else if (m_wait + 1 == TIMEOUT) begin
                    m_busy = 0; m_cause = 2;
                end else m_wait++;
            end
            if (start) begin
                m_addr = pc_in;
                if (pc_in[1:0] != 2'b00) m_cause = 1;
                else begin m_busy = 1; m_wait = 0; end
            end
        end
    end

    bit chk_en = 1'b0;

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        bit faulted;
        bit exp_valid;
        bit exp_stall;
        if (chk_en) begin
            faulted   = (m_cause != 0);
            exp_valid = m_have && !redirect;
            exp_stall = faulted || !(redirect || (exp_valid && instr_ready));
            chk("model imem_req",    32'(imem_req),    32'(m_busy && !faulted));
            chk("model imem_addr",   imem_addr,        m_addr);
            chk("model instr_out",   instr_out,        m_out);
            chk("model instr_pc",    instr_pc,         m_pc);
            chk("model instr_valid", 32'(instr_valid), 32'(exp_valid));
            chk("model pc_stall",    32'(pc_stall),    32'(exp_stall));
            chk("model fetch_fault", 32'(fetch_fault), 32'(faulted));
            chk("model fault_cause", 32'(fault_cause), 32'(m_cause));
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    initial begin
        int req_cnt;
        int valid_cnt;
        logic [31:0] w300;

        rst = 1'b0; pc_in = '0; fetch_en = 1'b0; redirect = 1'b0;
        instr_ready = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        // Reset for two edges, then release.
        cycle();
        cycle();
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst instr_valid", 32'(instr_valid), 32'd0);
        chk("rst instr_out",   instr_out,        32'h0000_0013);
        chk("rst imem_req",    32'(imem_req),    32'd0);
        chk("rst pc_stall",    32'(pc_stall),    32'd1);

        // Zero-wait fetch from 0x100, consumed immediately.
        pc_in = 32'h100; fetch_en = 1'b1; instr_ready = 1'b1;
        force_en = 1'b1; force_data = 32'h0050_0093;
        cycle();
        fetch_en = 1'b0;
        @(negedge clk);
        chk("t2 imem_addr", imem_addr, 32'h100);
        chk("t2 early valid", 32'(instr_valid), 32'd0);
        cycle();
        @(negedge clk);
        chk("t2 instr_valid", 32'(instr_valid), 32'd1);
        chk("t2 instr_pc",    instr_pc,         32'h100);
        chk("t2 instr_out",   instr_out,        32'h0050_0093);
        chk("t2 accept stall", 32'(pc_stall),   32'd0);
        cycle();
        @(negedge clk);
        chk("t2 post stall", 32'(pc_stall), 32'd1);
        force_en = 1'b0;

        // Redirect lands on the same cycle as the ack: the word is dropped.
        instr_ready = 1'b0; pc_in = 32'h200; fetch_en = 1'b1;
        force_en = 1'b1; force_data = 32'hDEAD_BEEF;
        valid_cnt = 0;
        cycle();
        redirect = 1'b1; fetch_en = 1'b0; pc_in = 32'h300;
        @(negedge clk);
        chk("t5 ack seen", 32'(imem_ack), 32'd1);
        if (instr_valid) valid_cnt++;
        cycle();
        redirect = 1'b0; fetch_en = 1'b1; force_en = 1'b0;
        @(negedge clk);
        if (instr_valid) valid_cnt++;
        chk("t5 idle req", 32'(imem_req), 32'd0);
        chk("t5 no valid", 32'(valid_cnt), 32'd0);
        cycle();
        fetch_en = 1'b0;
        @(negedge clk);
        chk("t5 new addr", imem_addr, 32'h300);
        chk("t5 new req",  32'(imem_req), 32'd1);
        w300 = mem_fn(32'h300);

        // Decode stalls for five cycles with the word held.
        for (int i = 0; i < 5; i++) begin
            cycle();
            @(negedge clk);
            chk("t6 hold valid", 32'(instr_valid), 32'd1);
            chk("t6 hold out",   instr_out,        w300);
            chk("t6 hold pc",    instr_pc,         32'h300);
            chk("t6 hold stall", 32'(pc_stall),    32'd1);
        end
        do_reset();
        @(negedge clk);
        chk("t6 rst valid", 32'(instr_valid), 32'd0);
        chk("t6 rst out",   instr_out,        NOP);
        chk("t6 rst pc",    instr_pc,         32'd0);

        // Misaligned PC faults without ever requesting.
        pc_in = 32'h102; fetch_en = 1'b1; req_cnt = 0;
        cycle();
        @(negedge clk);
        if (imem_req) req_cnt++;
        chk("t3 fault", 32'(fetch_fault), 32'd1);
        chk("t3 cause", 32'(fault_cause), 32'd1);
        redirect = 1'b1;
        cycle();
        @(negedge clk);
        if (imem_req) req_cnt++;
        chk("t3 sticky cause", 32'(fault_cause), 32'd1);
        chk("t3 fault stall",  32'(pc_stall),    32'd1);
        chk("t3 no req",       32'(req_cnt),     32'd0);
        redirect = 1'b0; fetch_en = 1'b0;
        do_reset();

        // Memory never acks: request held TIMEOUT cycles, then timeout fault.
        mem_mode = 2; pc_in = 32'h400; fetch_en = 1'b1; req_cnt = 0;
        cycle();
        fetch_en = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (imem_req) req_cnt++;
            cycle();
        end
        @(negedge clk);
        chk("t4 req cycles", 32'(req_cnt),     32'd16);
        chk("t4 fault",      32'(fetch_fault), 32'd1);
        chk("t4 cause",      32'(fault_cause), 32'd2);
        do_reset();

        // Randomized traffic with variable memory latency.
        mem_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            rst         = ($urandom_range(0, 49) != 0);
            fetch_en    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 9) == 0);
            instr_ready = ($urandom_range(0, 1) == 1);
            pc_in       = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 199) == 0) pc_in[1:0] = 2'($urandom_range(1, 3));
        end
        cycle();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
